multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle load/store datapath; `ILLEGAL_TRAP_EN routes unsupported opcodes to a sticky TRAP state.
// Latency: addi 4, ld 5, sd 4, beq 3 cycles with memory always ready; every mem_ready=0 cycle adds one.
// Backpressure: FETCH and MEM hold mem_req high and stall until mem_ready=1.
module multicycle_ctrl #(
    parameter logic [31:0] INSTRET_RST = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic        illegal
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t      state_q, state_d;
    logic [6:0]  op_q;
    logic [31:0] instret_q;
    logic        retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= 7'd0;
            instret_q <= INSTRET_RST;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE)
                op_q <= opcode;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_IMM, OP_LD, OP_SD, OP_BEQ: state_d = EXEC;
`ifdef ILLEGAL_TRAP_EN
                    default: state_d = TRAP;
`else
                    // Unsupported opcodes retire as a NOP.
                    default: begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
`endif
                endcase
            end
            EXEC: begin
                case (op_q)
                    OP_IMM: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                        state_d = WB;
                    end
                    OP_LD, OP_SD: begin
                        alu_src = 1'b1;
                        state_d = MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = 2'b01;
                        pc_write = zero;
                        pc_sel   = zero;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SD);
                if (mem_ready) begin
                    retire  = (op_q == OP_SD);
                    state_d = (op_q == OP_SD) ? FETCH : WB;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LD);
                retire     = 1'b1;
                state_d    = FETCH;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        // Reset silences every strobe, abandoning any in-flight access.
        if (reset) begin
            state_d    = FETCH;
            retire     = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_sel     = 1'b0;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == TRAP) && !reset;
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction table, corner-case sequences and randomized instruction stream.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // ctl vector: {mem_req, mem_we, ir_write, pc_write, pc_sel, alu_src, alu_op, reg_write, mem_to_reg, illegal}
    localparam logic [10:0] C_REQ = 11'h400;
    localparam logic [10:0] C_WE  = 11'h200;
    localparam logic [10:0] C_IRW = 11'h100;
    localparam logic [10:0] C_PCW = 11'h080;
    localparam logic [10:0] C_PCS = 11'h040;
    localparam logic [10:0] C_SRC = 11'h020;
    localparam logic [10:0] C_FUN = 11'h010;
    localparam logic [10:0] C_SUB = 11'h008;
    localparam logic [10:0] C_RW  = 11'h004;
    localparam logic [10:0] C_M2R = 11'h002;
    localparam logic [10:0] C_ILL = 11'h001;

    typedef struct {
        logic [6:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [6:0]  opcode;
    logic        mem_req, mem_we, ir_write, pc_write, pc_sel, alu_src, reg_write, mem_to_reg, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instret;

    logic        w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_pc_sel, w_alu_src, w_reg_write, w_mem_to_reg, w_illegal;
    logic [1:0]  w_alu_op;
    logic [2:0]  w_state;
    logic [31:0] w_instret;

    logic [10:0] ctl_vec;
    assign ctl_vec = {mem_req, mem_we, ir_write, pc_write, pc_sel, alu_src, alu_op, reg_write, mem_to_reg, illegal};

    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    logic [31:0] m_instret = 32'd0;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .state(state), .instret(instret), .illegal(illegal)
    );

    multicycle_ctrl #(.INSTRET_RST(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .ir_write(w_ir_write), .pc_write(w_pc_write),
        .pc_sel(w_pc_sel), .alu_src(w_alu_src), .alu_op(w_alu_op), .reg_write(w_reg_write),
        .mem_to_reg(w_mem_to_reg), .state(w_state), .instret(w_instret), .illegal(w_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One clock: drive inputs after the edge, compare at the falling edge.
    task automatic step(input logic mr, input logic [6:0] op, input logic z,
                        input logic [2:0] est, input logic [10:0] ectl);
        mem_ready = mr;
        opcode    = op;
        zero      = z;
        @(negedge clk);
        check("state", {29'd0, state}, {29'd0, est});
        check("ctl", {21'd0, ctl_vec}, {21'd0, ectl});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ctl_in_reset", {21'd0, ctl_vec}, 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b0;
        mem_ready = 1'b0;
        m_instret = 32'd0;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_instret", instret, 32'd0);
        step(1'b0, 7'($urandom), 1'b0, 3'd0, C_REQ);
    endtask

    // Expected per-cycle trace of one instruction, derived from its class.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw, output int ncyc);
        int c0;
        c0 = cyc;
        for (int i = 0; i < fw; i++) step(1'b0, 7'($urandom), z, 3'd0, C_REQ);
        step(1'b1, 7'($urandom), z, 3'd0, C_REQ | C_IRW | C_PCW);
        step(rb(), op, z, 3'd1, 11'd0);
        case (op)
            OP_ADDI: begin
                step(rb(), op, z, 3'd2, C_SRC | C_FUN);
                step(rb(), op, z, 3'd4, C_RW);
                m_instret++;
            end
            OP_LD: begin
                step(rb(), op, z, 3'd2, C_SRC);
                for (int i = 0; i < mw; i++) step(1'b0, op, z, 3'd3, C_REQ);
                step(1'b1, op, z, 3'd3, C_REQ);
                step(rb(), op, z, 3'd4, C_RW | C_M2R);
                m_instret++;
            end
            OP_SD: begin
                step(rb(), op, z, 3'd2, C_SRC);
                for (int i = 0; i < mw; i++) step(1'b0, op, z, 3'd3, C_REQ | C_WE);
                step(1'b1, op, z, 3'd3, C_REQ | C_WE);
                m_instret++;
            end
            OP_BEQ: begin
                step(rb(), op, z, 3'd2, C_SUB | (z ? (C_PCW | C_PCS) : 11'd0));
                m_instret++;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) step(rb(), 7'($urandom), rb(), 3'd7, C_ILL);
`else
                m_instret++;
`endif
            end
        endcase
        ncyc = cyc - c0;
        check("instret", instret, m_instret);
    endtask

    initial begin
        int n;
        logic [6:0] op;
        reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0;
        @(posedge clk);
        #1;
        reset_dut();
        check("wrap_preset", w_instret, 32'hFFFF_FFFF);

        tbl.push_back('{OP_ADDI, 1'b0, 0, 0, 4});
        tbl.push_back('{OP_LD,   1'b0, 0, 0, 5});
        tbl.push_back('{OP_SD,   1'b0, 0, 0, 4});
        tbl.push_back('{OP_BEQ,  1'b1, 0, 0, 3});
        tbl.push_back('{OP_BEQ,  1'b0, 0, 0, 3});
        tbl.push_back('{OP_LD,   1'b0, 0, 3, 8});
        tbl.push_back('{OP_SD,   1'b1, 2, 1, 7});
        tbl.push_back('{OP_ADDI, 1'b1, 1, 0, 5});
`ifndef ILLEGAL_TRAP_EN
        tbl.push_back('{OP_LUI,  1'b0, 0, 0, 2});
`endif
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, n);
            check("latency", n, tbl[i].cycles);
            if (i == 0) check("wrap_to_zero", w_instret, 32'd0);
        end

        // Reset while sd is waiting in MEM: the store must be dropped.
        step(1'b1, 7'($urandom), 1'b0, 3'd0, C_REQ | C_IRW | C_PCW);
        step(rb(), OP_SD, 1'b0, 3'd1, 11'd0);
        step(rb(), OP_SD, 1'b0, 3'd2, C_SRC);
        step(1'b0, OP_SD, 1'b0, 3'd3, C_REQ | C_WE);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("ctl_reset_mid_mem", {21'd0, ctl_vec}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        m_instret = 32'd0;
        check("post_rst_instret", instret, 32'd0);
        step(1'b0, OP_SD, 1'b0, 3'd0, C_REQ);
        run_instr(OP_ADDI, 1'b0, 0, 0, n);

`ifdef ILLEGAL_TRAP_EN
        run_instr(OP_LUI, 1'b0, 0, 0, n);
        reset_dut();
`endif

        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 4))
                0: op = OP_ADDI;
                1: op = OP_LD;
                2: op = OP_SD;
                3: op = OP_BEQ;
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    op = OP_ADDI;
`else
                    do op = 7'($urandom);
                    while (op == OP_ADDI || op == OP_LD || op == OP_SD || op == OP_BEQ);
`endif
                end
            endcase
            run_instr(op, rb(), $urandom_range(0, 3), $urandom_range(0, 3), n);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
